// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: fetch FSM states and fixed instruction encodings.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR_WORD    = 32'h0000_0013;
  localparam logic [XLEN-1:0] EBREAK_INSTR_WORD = 32'h0010_0073;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2,
    ST_TRAP = 2'd3
  } if_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register; priority is reset, then bubble, then load, otherwise hold.
module if_id_reg
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_WORD
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_load,
  input  logic            i_bubble,
  input  logic [XLEN-1:0] i_instr,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_pc_plus4,
  output logic [XLEN-1:0] o_instr,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_pc_plus4,
  output logic            o_valid
);

  logic [XLEN-1:0] r_instr;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_pc_plus4;
  logic            r_valid;

  // A bubble only kills the instruction; the pc fields keep their last values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_instr    <= NOP_INSTR;
      r_pc       <= '0;
      r_pc_plus4 <= '0;
      r_valid    <= 1'b0;
    end else if (i_bubble) begin
      r_instr    <= NOP_INSTR;
      r_valid    <= 1'b0;
    end else if (i_load) begin
      r_instr    <= i_instr;
      r_pc       <= i_pc;
      r_pc_plus4 <= i_pc_plus4;
      r_valid    <= 1'b1;
    end
  end

  assign o_instr    = r_instr;
  assign o_pc       = r_pc;
  assign o_pc_plus4 = r_pc_plus4;
  assign o_valid    = r_valid;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, BOOT/RUN/HALT/TRAP control and IF/ID register.
// Define IF_MISALIGN_TRAP_EN to trap on misaligned redirects instead of masking the low bits.
module if_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR    = NOP_INSTR_WORD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] pc,
  input  logic [31:0] instruction_data,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic        halted,
  output logic        fetch_misaligned
);

  if_state_e       r_state;
  logic [XLEN-1:0] r_pc;
  logic            r_halted;
  logic            r_fetch_misaligned;

  logic [XLEN-1:0] w_pc_plus4;
  logic [XLEN-1:0] w_target;
  logic            w_target_misaligned;
  logic            w_can_redirect;
  logic            w_redirect;
  logic            w_fetch;
  logic            w_ebreak;
  logic            w_bubble;

`ifdef IF_MISALIGN_TRAP_EN
  assign w_target            = branch_target;
  assign w_target_misaligned = |branch_target[1:0];
`else
  assign w_target            = branch_target & ~32'h0000_0003;
  assign w_target_misaligned = 1'b0;
`endif

  assign w_pc_plus4     = r_pc + 32'd4;
  assign w_can_redirect = (r_state == ST_RUN) || (r_state == ST_HALT);
  assign w_redirect     = w_can_redirect && branch_taken;
  assign w_fetch        = (r_state == ST_RUN) && !branch_taken && !flush && !stall;
  assign w_ebreak       = w_fetch && (instruction_data == EBREAK_INSTR_WORD);

  // Everything except a plain fetch or a RUN-state stall turns IF/ID into a bubble.
  assign w_bubble = w_redirect
                 || ((r_state == ST_RUN) && flush)
                 || (r_state == ST_BOOT)
                 || (r_state == ST_HALT)
                 || (r_state == ST_TRAP);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state            <= ST_BOOT;
      r_pc               <= RESET_VECTOR;
      r_halted           <= 1'b0;
      r_fetch_misaligned <= 1'b0;
    end else begin
      case (r_state)
        ST_BOOT: r_state <= ST_RUN;
        ST_RUN, ST_HALT: begin
          if (branch_taken) begin
            r_pc <= w_target;
            if (w_target_misaligned) begin
              r_state            <= ST_TRAP;
              r_halted           <= 1'b1;
              r_fetch_misaligned <= 1'b1;
            end else begin
              r_state  <= ST_RUN;
              r_halted <= 1'b0;
            end
          end else if (w_ebreak) begin
            // EBREAK is latched into IF/ID, pc stays on it.
            r_state  <= ST_HALT;
            r_halted <= 1'b1;
          end else if (w_fetch) begin
            r_pc <= w_pc_plus4;
          end
        end
        ST_TRAP: r_state <= ST_TRAP;
        default: r_state <= ST_BOOT;
      endcase
    end
  end

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_fetch),
    .i_bubble   (w_bubble),
    .i_instr    (instruction_data),
    .i_pc       (r_pc),
    .i_pc_plus4 (w_pc_plus4),
    .o_instr    (if_id_instr),
    .o_pc       (if_id_pc),
    .o_pc_plus4 (if_id_pc_plus4),
    .o_valid    (if_id_valid)
  );

  assign pc               = r_pc;
  assign halted           = r_halted;
  assign fetch_misaligned = r_fetch_misaligned;

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
- REQ-001: Parameter RESET_VECTOR, default 32'h0000_0000, PC value loaded on reset.
- REQ-002: Parameter NOP_INSTR, default 32'h0000_0013, bubble encoding placed in IF/ID when invalid.
- REQ-003: clk  input  1  single clock; all state updates on its rising edge.
- REQ-004: rst  input  1  synchronous, active-high reset.
- REQ-005: stall  input  1  hazard unit request to hold PC and IF/ID.
- REQ-006: flush  input  1  invalidate IF/ID contents.
- REQ-007: branch_taken  input  1  redirect request from execute.
- REQ-008: branch_target  input  32  redirect address.
- REQ-009: pc  output  32  fetch address to instruction_memory.
- REQ-010: instruction_data  input  32  combinational instruction word from instruction_memory, little-endian bytes pc..pc+3.
- REQ-011: if_id_instr, if_id_pc, if_id_pc_plus4  output  32 each  IF/ID register contents.
- REQ-012: if_id_valid  output  1  IF/ID holds a real instruction.
- REQ-013: halted  output  1  fetch stopped.
- REQ-014: fetch_misaligned  output  1  sticky misaligned-redirect flag.

Function
- REQ-015: FSM states BOOT, RUN, HALT, TRAP. Every event below is evaluated at a rising edge. Priority: rst > branch_taken > flush > stall > normal fetch.
- REQ-016: BOOT lasts exactly one cycle after rst deasserts: pc holds, IF/ID holds bubble, next state RUN.
- REQ-017: RUN normal fetch (no stall/flush/branch):
  - IF/ID <= {instruction_data, pc, pc+4}, if_id_valid <= 1.
  - pc <= pc+4, modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000).
- REQ-018: RUN with stall only: pc and all IF/ID outputs hold their values.
- REQ-019: flush without branch_taken: IF/ID <= bubble (instr=NOP_INSTR, valid=0, pc fields unchanged); pc holds; flush overrides stall.
- REQ-020: branch_taken, in RUN or HALT, regardless of stall or flush:
  - pc <= branch_target.
  - IF/ID <= bubble.
  - next state RUN.
- REQ-021: EBREAK fetch: in RUN, normal fetch with instruction_data == 32'h0010_0073 latches it (valid=1), holds pc, and goes to HALT.
- REQ-022: HALT:
  - halted=1; pc holds.
  - IF/ID becomes bubble on the following edge and stays bubble.
  - stall and flush have no effect.
  - Only branch_taken (wrong-path EBREAK) or rst leaves HALT.
- REQ-023: branch_taken in the same cycle as an EBREAK fetch: the branch wins and no HALT is entered.
- REQ-024: TRAP (see REQ-029): halted=1, pc holds, IF/ID bubble; only rst leaves TRAP; branch_taken is ignored.
- REQ-025: Latency: an instruction at address A appears on if_id_instr one edge after pc==A with no stall; a redirect costs one bubble.

Reset
- REQ-026: While rst is high at an edge, all of the following load:
  - pc=RESET_VECTOR.
  - if_id_instr=NOP_INSTR, if_id_pc=0, if_id_pc_plus4=0, if_id_valid=0.
  - halted=0, fetch_misaligned=0.
  - state=BOOT.
- REQ-027: rst asserted mid-operation (any state, including concurrent stall/branch) overrides everything in the same edge.

Configuration
- REQ-028: Macro IF_MISALIGN_TRAP_EN selects misaligned-redirect handling.
- REQ-029: With IF_MISALIGN_TRAP_EN defined, branch_taken with branch_target[1:0]!=0:
  - pc <= branch_target unmodified.
  - fetch_misaligned <= 1 (sticky until rst).
  - next state TRAP.
- REQ-030: Without IF_MISALIGN_TRAP_EN, branch_target[1:0] is forced to 2'b00, fetch_misaligned is tied 0, and TRAP is unreachable.

Structure
- REQ-031: Shared package riscv_pkg holds the FSM state typedef and the NOP_INSTR (32'h0000_0013) and EBREAK (32'h0010_0073) constants.
- REQ-032: The IF/ID register is a sub-module if_id_reg with load, bubble and hold controls; the PC register and FSM stay in if_stage.

Verification
- REQ-033: Reset, then 4 free-running cycles from 0x0 with imem words W0..W3 -> pc sequence 0,0,4,8,C and if_id_instr W0,W1,W2 with valid=1.
- REQ-034: stall high 2 cycles at pc=0x8 -> pc stays 0x8 and IF/ID stays W1 for 2 cycles, then resumes with W2.
- REQ-035: branch_taken with target 0x40 and stall high together -> pc=0x40 and if_id_valid=0 next cycle; W(0x40) latched the cycle after.
- REQ-036: EBREAK at 0x10 -> halted=1 and pc=0x10 held; a later branch_taken with target 0x20 returns to RUN with pc=0x20 and halted=0.
- REQ-037: With IF_MISALIGN_TRAP_EN, branch_target=0x22 -> fetch_misaligned=1, halted=1, pc=0x22, and a further branch to 0x30 is ignored. Without the macro, pc=0x20 and fetch continues.
- REQ-038: pc=0xFFFF_FFFC with normal fetch -> pc wraps to 0x0. rst asserted during HALT -> all REQ-026 values on the next edge.
